// File: rtl/cr16_pkg.sv
// Shared CR16 control definitions: FSM states, instruction classes, opcode/extension codes,
// condition codes, flag bit positions and the PC/writeback mux encodings.
package cr16_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_LD_ADDR, S_LD_WB, S_STORE, S_BRANCH, S_JUMP, S_HALT
  } state_e;

  typedef enum logic [2:0] {
    CLASS_RR, CLASS_IMM, CLASS_LOAD, CLASS_STOR, CLASS_JAL, CLASS_JCOND, CLASS_BCOND
  } instr_class_e;

  localparam logic [3:0] CLS_RR    = 4'b0000;
  localparam logic [3:0] CLS_EXT   = 4'b0100;
  localparam logic [3:0] CLS_BCOND = 4'b1100;

  localparam logic [3:0] EXT_LOAD  = 4'b0000;
  localparam logic [3:0] EXT_STOR  = 4'b0100;
  localparam logic [3:0] EXT_JAL   = 4'b1000;
  localparam logic [3:0] EXT_JCOND = 4'b1100;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_CMP = 4'b1011;

  localparam logic [3:0] COND_EQ = 4'd0;
  localparam logic [3:0] COND_NE = 4'd1;
  localparam logic [3:0] COND_CS = 4'd2;
  localparam logic [3:0] COND_CC = 4'd3;
  localparam logic [3:0] COND_HI = 4'd4;
  localparam logic [3:0] COND_LS = 4'd5;
  localparam logic [3:0] COND_GT = 4'd6;
  localparam logic [3:0] COND_LE = 4'd7;
  localparam logic [3:0] COND_FS = 4'd8;
  localparam logic [3:0] COND_FC = 4'd9;
  localparam logic [3:0] COND_LO = 4'd10;
  localparam logic [3:0] COND_HS = 4'd11;
  localparam logic [3:0] COND_LT = 4'd12;
  localparam logic [3:0] COND_GE = 4'd13;
  localparam logic [3:0] COND_UC = 4'd14;
  localparam logic [3:0] COND_NV = 4'd15;

  localparam int FLAG_N = 4;
  localparam int FLAG_Z = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_L = 1;
  localparam int FLAG_C = 0;

  localparam logic [1:0] PC_SEL_INC  = 2'b00;
  localparam logic [1:0] PC_SEL_DISP = 2'b01;
  localparam logic [1:0] PC_SEL_REG  = 2'b10;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  // Unrecognised extension codes under 0100 fall back to the immediate ALU class.
  function automatic instr_class_e decodeClass(input logic [3:0] top, input logic [3:0] ext);
    case (top)
      CLS_RR:    return CLASS_RR;
      CLS_BCOND: return CLASS_BCOND;
      CLS_EXT: begin
        case (ext)
          EXT_LOAD:  return CLASS_LOAD;
          EXT_STOR:  return CLASS_STOR;
          EXT_JAL:   return CLASS_JAL;
          EXT_JCOND: return CLASS_JCOND;
          default:   return CLASS_IMM;
        endcase
      end
      default:   return CLASS_IMM;
    endcase
  endfunction

endpackage

// File: rtl/cr16_cond_eval.sv
// Evaluates a CR16 condition code against the {N,Z,F,L,C} flag vector.
module cr16_cond_eval
  import cr16_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [4:0] flags_i,
  output logic       taken_o
);

  logic n, z, f, l, c;

  assign n = flags_i[FLAG_N];
  assign z = flags_i[FLAG_Z];
  assign f = flags_i[FLAG_F];
  assign l = flags_i[FLAG_L];
  assign c = flags_i[FLAG_C];

  always_comb begin
    taken_o = 1'b0;
    case (cond_i)
      COND_EQ: taken_o = z;
      COND_NE: taken_o = !z;
      COND_CS: taken_o = c;
      COND_CC: taken_o = !c;
      COND_HI: taken_o = l;
      COND_LS: taken_o = !l;
      COND_GT: taken_o = n;
      COND_LE: taken_o = !n;
      COND_FS: taken_o = f;
      COND_FC: taken_o = !f;
      COND_LO: taken_o = !l && !z;
      COND_HS: taken_o = l || z;
      COND_LT: taken_o = !n && !z;
      COND_GE: taken_o = n || z;
      COND_UC: taken_o = 1'b1;
      COND_NV: taken_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/cr16_control_fsm.sv
// Multicycle CR16 control FSM: fetch/decode/execute sequencing with memory wait states,
// branch/jump resolution and an optional retired-instruction halt limit.
module cr16_control_fsm
  import cr16_pkg::*;
#(
  parameter int NREGS      = 16,
  parameter int DATA_W     = 16,
  parameter int HALT_AFTER = 0,
  parameter int CNT_W      = 16,
  localparam int RIDX_W    = $clog2(NREGS)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [15:0]       instr_i,
  input  logic [4:0]        flags_i,
  input  logic              mem_ready_i,
  output logic              ir_en_o,
  output logic              pc_en_o,
  output logic [1:0]        pc_sel_o,
  output logic              addr_sel_o,
  output logic              mem_we_o,
  output logic              reg_we_o,
  output logic [NREGS-1:0]  reg_en_o,
  output logic [1:0]        wb_sel_o,
  output logic [RIDX_W-1:0] rsrc_o,
  output logic [RIDX_W-1:0] rdest_o,
  output logic [3:0]        op_o,
  output logic              imm_en_o,
  output logic [7:0]        imm8_o,
  output logic [DATA_W-1:0] disp_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_o
);

  state_e            state_q, state_d;
  logic [15:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  retired_q, retired_d;

  instr_class_e      irClass, newClass;
  logic [3:0]        aluOp;
  logic              condTaken;
  logic              inExecute;
  logic [CNT_W-1:0]  retiredInc;
  logic              haltHit;

  cr16_cond_eval u_cond_eval (
    .cond_i  (ir_q[11:8]),
    .flags_i (flags_i),
    .taken_o (condTaken)
  );

  assign irClass    = decodeClass(ir_q[15:12], ir_q[7:4]);
  assign newClass   = decodeClass(instr_i[15:12], instr_i[7:4]);
  assign retiredInc = retired_q + CNT_W'(1);
  assign haltHit    = (HALT_AFTER != 0) && (retiredInc == CNT_W'(HALT_AFTER));
  assign inExecute  = state_q inside {S_EXEC, S_LD_ADDR, S_LD_WB, S_STORE, S_BRANCH, S_JUMP};
  assign retired_o  = retired_q;

  always_comb begin
    aluOp = OP_NOP;
    if (irClass == CLASS_RR)       aluOp = ir_q[7:4];
    else if (irClass == CLASS_IMM) aluOp = ir_q[15:12];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_FETCH;
      ir_q      <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ir_d       = ir_q;
    retired_d  = retired_q;
    ir_en_o    = 1'b0;
    pc_en_o    = 1'b0;
    pc_sel_o   = PC_SEL_INC;
    addr_sel_o = 1'b0;
    mem_we_o   = 1'b0;
    reg_we_o   = 1'b0;
    reg_en_o   = '0;
    wb_sel_o   = WB_SEL_ALU;
    rsrc_o     = '0;
    rdest_o    = '0;
    op_o       = '0;
    imm_en_o   = 1'b0;
    imm8_o     = '0;
    disp_o     = '0;
    halted_o   = 1'b0;

    // Instruction fields only appear while an instruction is executing, so idle states stay quiet.
    if (inExecute) begin
      rsrc_o   = ir_q[RIDX_W-1:0];
      rdest_o  = ir_q[8 +: RIDX_W];
      op_o     = aluOp;
      imm_en_o = (irClass == CLASS_IMM);
      imm8_o   = ir_q[7:0];
      disp_o   = DATA_W'($signed(ir_q[7:0]));
    end

    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) state_d = S_DECODE;
      end
      S_DECODE: begin
        ir_en_o = 1'b1;
        ir_d    = instr_i;
        case (newClass)
          CLASS_LOAD:              state_d = S_LD_ADDR;
          CLASS_STOR:              state_d = S_STORE;
          CLASS_BCOND:             state_d = S_BRANCH;
          CLASS_JAL, CLASS_JCOND:  state_d = S_JUMP;
          default:                 state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        pc_en_o  = 1'b1;
        reg_we_o = (aluOp != OP_CMP) && (aluOp != OP_NOP);
      end
      S_LD_ADDR: begin
        addr_sel_o = 1'b1;
        if (mem_ready_i) state_d = S_LD_WB;
      end
      S_LD_WB: begin
        wb_sel_o = WB_SEL_MEM;
        reg_we_o = 1'b1;
        pc_en_o  = 1'b1;
      end
      S_STORE: begin
        addr_sel_o = 1'b1;
        mem_we_o   = 1'b1;
        pc_en_o    = mem_ready_i;
      end
      S_BRANCH: begin
        pc_en_o  = 1'b1;
        pc_sel_o = condTaken ? PC_SEL_DISP : PC_SEL_INC;
      end
      S_JUMP: begin
        pc_en_o = 1'b1;
        if (irClass == CLASS_JAL) begin
          pc_sel_o = PC_SEL_REG;
          reg_we_o = 1'b1;
          wb_sel_o = WB_SEL_LINK;
        end else begin
          pc_sel_o = condTaken ? PC_SEL_REG : PC_SEL_INC;
        end
      end
      S_HALT: begin
        halted_o = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase

    // Every PC update retires one instruction and decides between the next fetch and halting.
    if (pc_en_o) begin
      retired_d = retiredInc;
      state_d   = haltHit ? S_HALT : S_FETCH;
    end

    if (reg_we_o) reg_en_o = NREGS'(1) << rdest_o;
  end

endmodule
